// File: rtl/multicycle_control.sv
// multicycle_control
//   Control unit for a multicycle 16-bit processor. A Moore FSM steps each
//   instruction through FETCH / DECODE / EXEC / MEM / WB. All datapath
//   controls are decoded from the registered state and the opcode latched in
//   DECODE. The only exceptions are the BEQ branch enable, which also looks at
//   the live zero_flag in EXEC, and MEM completion, which follows mem_ready.
//
// Parameters
//   MEM_TIMEOUT     maximum MEM cycles spent waiting for mem_ready (1..15)
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   instr[15:0]     instruction register output, opcode = instr[15:12]
//   zero_flag       ALU zero result in the current EXEC cycle
//   mem_ready       data memory handshake, 1 = access completes this cycle
//   IR_load         IR load enable (FETCH)
//   PC_write        PC write enable
//   PC_src          PC source, 0 = PC+1, 1 = branch/jump target
//   Source2_select  ALU operand 2, 1 = Ext_Immed_Addr, 0 = Dout2
//   ALU_op[2:0]     000 ADD, 001 SUB, 010 AND, 011 OR
//   RegWrite, MemRead, MemWrite, Mem_to_Reg   register file / memory controls
//   halted          FSM is in the absorbing HALT state
//   illegal_op      EXEC of an unassigned opcode (1010..1110)
//   mem_timeout     one-cycle pulse, shown in the FETCH that follows an
//                   abandoned memory access
//   retired[15:0]   count of completed instructions, wraps at 0xFFFF
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        IR_load,
    output logic        PC_write,
    output logic        PC_src,
    output logic        Source2_select,
    output logic [2:0]  ALU_op,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem_to_Reg,
    output logic        halted,
    output logic        illegal_op,
    output logic        mem_timeout,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_SUBI  = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    state_t      state;
    logic [3:0]  op_q;
    logic [3:0]  wait_cnt;
    logic        timeout_q;

    // Only the opcode field matters to the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            wait_cnt  <= '0;
            retired   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                IDLE:   state <= FETCH;
                FETCH:  state <= DECODE;
                DECODE: begin
                    op_q  <= instr[15:12];
                    state <= (instr[15:12] == OP_HALT) ? HALT : EXEC;
                end
                EXEC: begin
                    wait_cnt <= '0;
                    unique case (op_q)
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_ADDI, OP_SUBI:  state <= WB;
                        OP_LOAD, OP_STORE: state <= MEM;
                        OP_BEQ, OP_JMP: begin
                            state   <= FETCH;
                            retired <= retired + 16'd1;
                        end
                        default:           state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        if (op_q == OP_LOAD) begin
                            state <= WB;
                        end else begin
                            state   <= FETCH;
                            retired <= retired + 16'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                        // The wait that brings the count to MEM_TIMEOUT abandons
                        // the access; the pulse is visible in the next FETCH.
                        if (int'(wait_cnt) + 1 >= MEM_TIMEOUT) begin
                            state     <= FETCH;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                WB: begin
                    state   <= FETCH;
                    retired <= retired + 16'd1;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_timeout = timeout_q;

    always_comb begin
        IR_load        = 1'b0;
        PC_write       = 1'b0;
        PC_src         = 1'b0;
        Source2_select = 1'b0;
        ALU_op         = ALU_ADD;
        RegWrite       = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        Mem_to_Reg     = 1'b0;
        halted         = 1'b0;
        illegal_op     = 1'b0;
        unique case (state)
            FETCH: begin
                IR_load  = 1'b1;
                PC_write = 1'b1;
            end
            EXEC: begin
                unique case (op_q)
                    OP_ADD:  ALU_op = ALU_ADD;
                    OP_SUB:  ALU_op = ALU_SUB;
                    OP_AND:  ALU_op = ALU_AND;
                    OP_OR:   ALU_op = ALU_OR;
                    OP_ADDI, OP_LOAD, OP_STORE: begin
                        Source2_select = 1'b1;
                        ALU_op         = ALU_ADD;
                    end
                    OP_SUBI: begin
                        Source2_select = 1'b1;
                        ALU_op         = ALU_SUB;
                    end
                    OP_BEQ: begin
                        ALU_op   = ALU_SUB;
                        PC_write = zero_flag;
                        PC_src   = zero_flag;
                    end
                    OP_JMP: begin
                        PC_write = 1'b1;
                        PC_src   = 1'b1;
                    end
                    default: illegal_op = 1'b1;
                endcase
            end
            MEM: begin
                MemRead  = (op_q == OP_LOAD);
                MemWrite = (op_q == OP_STORE);
            end
            WB: begin
                RegWrite   = 1'b1;
                Mem_to_Reg = (op_q == OP_LOAD);
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed bench for multicycle_control. An instruction-level model expands
//   each instruction into its expected per-cycle control vectors (plus the
//   inputs to drive on that cycle). A driver walks that list and a single
//   compare process checks every meaningful cycle against it.
module tb_multicycle_control;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        zero_flag;
    logic        mem_ready;
    logic        IR_load, PC_write, PC_src, Source2_select;
    logic [2:0]  ALU_op;
    logic        RegWrite, MemRead, MemWrite, Mem_to_Reg;
    logic        halted, illegal_op, mem_timeout;
    logic [15:0] retired;

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero_flag(zero_flag),
        .mem_ready(mem_ready), .IR_load(IR_load), .PC_write(PC_write),
        .PC_src(PC_src), .Source2_select(Source2_select), .ALU_op(ALU_op),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Mem_to_Reg(Mem_to_Reg), .halted(halted), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ir_load, pc_write, pc_src, src2;
        logic [2:0]  alu_op;
        logic        reg_write, mem_read, mem_write, mem_to_reg;
        logic        halted, illegal_op, mem_timeout;
        logic [15:0] retired;
    } ctl_t;

    typedef struct {
        logic [15:0] instr;
        logic        zf, mr, rst, chk;
        ctl_t        exp;
    } rec_t;

    rec_t        recs[$];
    int unsigned retired_m = 0;
    bit          pend_to   = 1'b0;
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          cur       = 0;
    bit          active    = 1'b0;
    int          seen_to   = 0;
    int          seen_halt = 0;

    function automatic ctl_t blank();
        ctl_t c;
        c = '0;
        c.retired = retired_m[15:0];
        return c;
    endfunction

    function automatic void push(input logic [15:0] ins, input logic zf,
                                 input logic mr, input logic chk, input ctl_t c);
        rec_t r;
        r.instr = ins; r.zf = zf; r.mr = mr; r.rst = 1'b0; r.chk = chk; r.exp = c;
        recs.push_back(r);
    endfunction

    // FETCH, DECODE and EXEC for a non-HALT instruction.
    function automatic void head(input logic [15:0] ins, input logic zf);
        ctl_t c;
        logic [3:0] op;
        op = ins[15:12];
        c = blank(); c.ir_load = 1'b1; c.pc_write = 1'b1; c.mem_timeout = pend_to;
        pend_to = 1'b0;
        push(ins, zf, 1'b0, 1'b1, c);
        c = blank();
        push(ins, zf, 1'b0, 1'b1, c);
        c = blank();
        c.src2       = op inside {4'h4, 4'h5, 4'h6, 4'h7};
        c.alu_op     = (op inside {4'h1, 4'h5, 4'h8}) ? 3'b001 :
                       (op == 4'h2) ? 3'b010 : (op == 4'h3) ? 3'b011 : 3'b000;
        c.pc_write   = (op == 4'h9) || (op == 4'h8 && zf);
        c.pc_src     = c.pc_write;
        c.illegal_op = (op >= 4'hA && op <= 4'hE);
        push(ins, zf, 1'b0, 1'b1, c);
        if (op == 4'h8 || op == 4'h9) retired_m++;
    endfunction

    // Whole instruction; waits = MEM cycles with mem_ready low before the
    // ready cycle, or a full timeout when completes is 0. Returns cycle count.
    function automatic int unsigned run_instr(input logic [15:0] ins, input logic zf,
                                              input int unsigned waits, input bit completes);
        int unsigned n0, total;
        ctl_t c;
        logic [3:0] op;
        n0 = recs.size();
        op = ins[15:12];
        head(ins, zf);
        if (op == 4'h6 || op == 4'h7) begin
            total = completes ? waits + 1 : TO;
            for (int unsigned i = 0; i < total; i++) begin
                c = blank(); c.mem_read = (op == 4'h6); c.mem_write = (op == 4'h7);
                push(ins, zf, completes && (i == total - 1), 1'b1, c);
            end
            if (!completes) pend_to = 1'b1;
            else if (op == 4'h7) retired_m++;
        end
        if (op <= 4'h5 || (op == 4'h6 && completes)) begin
            c = blank(); c.reg_write = 1'b1; c.mem_to_reg = (op == 4'h6);
            push(ins, zf, 1'b0, 1'b1, c);
            retired_m++;
        end
        return recs.size() - n0;
    endfunction

    function automatic void run_halt(input int unsigned cycles);
        ctl_t c;
        c = blank(); c.ir_load = 1'b1; c.pc_write = 1'b1; c.mem_timeout = pend_to;
        pend_to = 1'b0;
        push(16'hF000, 1'b0, 1'b0, 1'b1, c);
        c = blank();
        push(16'hF000, 1'b0, 1'b0, 1'b1, c);
        for (int unsigned i = 0; i < cycles; i++) begin
            c = blank(); c.halted = 1'b1;
            // Toggle inputs to show HALT ignores them.
            push(16'h4123, i[0], 1'b1, 1'b1, c);
        end
    endfunction

    // Raise rst on the last queued cycle; the next cycle must be IDLE.
    function automatic void apply_reset();
        rec_t r;
        ctl_t c;
        r = recs.pop_back();
        r.rst = 1'b1;
        recs.push_back(r);
        retired_m = 0;
        pend_to   = 1'b0;
        c = blank();
        push(16'h0000, 1'b0, 1'b0, 1'b1, c);
    endfunction

    task automatic pin(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    initial begin
        int unsigned n, r0;
        ctl_t c;
        rec_t r;
        r.instr = 16'h0000; r.zf = 1'b0; r.mr = 1'b0; r.rst = 1'b1; r.chk = 1'b0;
        r.exp = '0;
        recs.push_back(r);
        c = blank();
        push(16'h0000, 1'b0, 1'b0, 1'b1, c);                   // IDLE after reset

        n = run_instr(16'h4123, 1'b1, 0, 1'b1);                  // ADDI
        pin("addi_len", int'(n), 4);
        pin("addi_retired", int'(retired_m), 1);
        void'(run_instr(16'h0123, 1'b1, 0, 1'b1));               // ADD
        void'(run_instr(16'h1123, 1'b1, 0, 1'b1));               // SUB
        void'(run_instr(16'h2123, 1'b0, 0, 1'b1));               // AND
        void'(run_instr(16'h3123, 1'b1, 0, 1'b1));               // OR
        void'(run_instr(16'h5123, 1'b0, 0, 1'b1));               // SUBI
        n = run_instr(16'h6120, 1'b0, 2, 1'b1);                  // LOAD, 2 waits
        pin("load_len", int'(n), 7);
        r0 = retired_m;
        n = run_instr(16'h8120, 1'b1, 0, 1'b1);                  // BEQ taken
        pin("beq_len", int'(n), 3);
        void'(run_instr(16'h8120, 1'b0, 0, 1'b1));               // BEQ not taken
        pin("beq_retired_delta", int'(retired_m - r0), 2);
        void'(run_instr(16'h9000, 1'b0, 0, 1'b1));               // JMP
        n = run_instr(16'h7120, 1'b0, 0, 1'b1);                  // STORE, ready at once
        pin("store_len", int'(n), 4);
        r0 = retired_m;
        n = run_instr(16'h7120, 1'b0, 0, 1'b0);                  // STORE timeout
        pin("store_to_len", int'(n), 3 + 15);
        pin("store_to_retired", int'(retired_m - r0), 0);
        void'(run_instr(16'h4123, 1'b0, 0, 1'b1));               // FETCH carries pulse
        void'(run_instr(16'hA000, 1'b1, 0, 1'b1));               // illegal
        void'(run_instr(16'hE000, 1'b1, 0, 1'b1));               // illegal
        void'(run_instr(16'h6120, 1'b0, 0, 1'b0));               // LOAD timeout
        void'(run_instr(16'h0123, 1'b0, 0, 1'b1));
        pin("retired_before_reset", int'(retired_m), 13);
        head(16'h6120, 1'b0);                                    // LOAD, reset mid-wait
        for (int i = 0; i < 3; i++) begin
            c = blank(); c.mem_read = 1'b1;
            push(16'h6120, 1'b0, 1'b0, 1'b1, c);
        end
        apply_reset();
        void'(run_instr(16'h4123, 1'b0, 0, 1'b1));
        run_halt(20);
        apply_reset();
        void'(run_instr(16'h4123, 1'b0, 0, 1'b1));

        for (int k = 0; k < recs.size(); k++) begin
            rst       = recs[k].rst;
            instr     = recs[k].instr;
            zero_flag = recs[k].zf;
            mem_ready = recs[k].mr;
            cur       = k;
            active    = 1'b1;
            @(posedge clk);
            #1;
        end
        active = 1'b0;
        @(negedge clk);
        pin("mem_timeout_pulses", seen_to, 2);
        pin("halted_cycles", seen_halt, 20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        ctl_t got;
        if (active && recs[cur].chk) begin
            got.ir_load = IR_load;       got.pc_write = PC_write;
            got.pc_src = PC_src;         got.src2 = Source2_select;
            got.alu_op = ALU_op;         got.reg_write = RegWrite;
            got.mem_read = MemRead;      got.mem_write = MemWrite;
            got.mem_to_reg = Mem_to_Reg; got.halted = halted;
            got.illegal_op = illegal_op; got.mem_timeout = mem_timeout;
            got.retired = retired;
            n_tests++;
            if (got !== recs[cur].exp) begin
                n_fail++;
                $display("FAIL ctl@cycle%0d instr=%h: got %h, required %h",
                         cur, recs[cur].instr, got, recs[cur].exp);
            end
            if (mem_timeout === 1'b1) seen_to++;
            if (halted === 1'b1) seen_halt++;
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL expose parameter MEM_TIMEOUT, default 15, meaning maximum cycles spent waiting in MEM for mem_ready.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 instr  input  16  instruction register output; opcode = instr[15:12].
REQ-005 zero_flag  input  1  ALU zero result for the current EXEC cycle.
REQ-006 mem_ready  input  1  data memory handshake; 1 = access completes this cycle.
REQ-007 IR_load, PC_write, PC_src  output  1 each  IR load enable; PC write enable; PC source (0 = PC+1, 1 = branch/jump target).
REQ-008 Source2_select  output  1  ALU operand-2 mux select (1 = Ext_Immed_Addr, 0 = Dout2).
REQ-009 ALU_op  output  3  000 ADD, 001 SUB, 010 AND, 011 OR.
REQ-010 RegWrite, MemRead, MemWrite, Mem_to_Reg  output  1 each  register file and data memory controls.
REQ-011 halted, illegal_op, mem_timeout  output  1 each  status flags.
REQ-012 retired  output  16  count of completed instructions.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs are decoded from the registered state and latched opcode op_q.
REQ-014 IDLE -> FETCH unconditionally; FETCH -> DECODE; IR_load=1 and PC_write=1 with PC_src=0 in FETCH.
REQ-015 SHALL latch op_q <= instr[15:12] in DECODE; DECODE -> EXEC, except opcode 1111 -> HALT.
REQ-016 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 ADDI, 0101 SUBI, 0110 LOAD, 0111 STORE, 1000 BEQ, 1001 JMP, 1111 HALT; 1010-1110 illegal.
REQ-017 In EXEC, Source2_select=1 for ADDI, SUBI, LOAD and STORE; Source2_select=0 otherwise.
REQ-018 In EXEC, ALU_op = ADD for ADD/ADDI/LOAD/STORE, SUB for SUB/SUBI/BEQ, AND for AND, OR for OR.
REQ-019 EXEC transitions: R/I-type -> WB; LOAD/STORE -> MEM; BEQ/JMP -> FETCH; illegal -> FETCH with illegal_op=1 for that EXEC cycle and no write enable asserted.
REQ-020 BEQ SHALL assert PC_write=1 and PC_src=1 in EXEC only when zero_flag=1; JMP SHALL assert both unconditionally.
REQ-021 MEM asserts MemRead=1 (LOAD) or MemWrite=1 (STORE) on every cycle in MEM until mem_ready=1; then LOAD -> WB and STORE -> FETCH.
REQ-022 A 4-bit wait counter SHALL clear on MEM entry and increment each MEM cycle with mem_ready=0; on reaching MEM_TIMEOUT, mem_timeout=1 for one cycle, the access is abandoned with no RegWrite, and the FSM goes to FETCH.
REQ-023 WB asserts RegWrite=1, with Mem_to_Reg=1 for LOAD and 0 otherwise; WB -> FETCH.
REQ-024 retired SHALL increment by 1 on the final state of each instruction (WB, STORE MEM completion, BEQ/JMP EXEC) and wrap from 0xFFFF to 0x0000; illegal, timed-out and HALT instructions SHALL NOT be counted.
REQ-025 Latencies: R/I-type 4 cycles; LOAD 4+n cycles; STORE 3+n cycles; BEQ/JMP 3 cycles; n = MEM cycles, with n >= 1.
REQ-026 HALT SHALL be absorbing: halted=1, and all enables 0 until rst.
REQ-027 Outputs not listed as asserted in a state SHALL be 0.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=IDLE, op_q=0, wait counter=0 and retired=0, overriding any in-progress transition including a pending MEM access.
REQ-029 In IDLE, all outputs SHALL be 0.

Verification
REQ-030 Reset, then instr=0x4123 (ADDI): FETCH IR_load=1, PC_write=1; EXEC Source2_select=1, ALU_op=000; WB RegWrite=1, Mem_to_Reg=0; retired=1.
REQ-031 instr=0x6120 (LOAD) with mem_ready low for 2 MEM cycles then high: MemRead=1 for 3 cycles; WB Mem_to_Reg=1; total 7 cycles.
REQ-032 BEQ 0x8120 with zero_flag=1, then with zero_flag=0: first EXEC PC_write=1, PC_src=1; second EXEC PC_write=0; retired increments by 2.
REQ-033 STORE with mem_ready held 0: mem_timeout pulses after 15 MEM cycles, then FETCH; MemWrite drops; retired unchanged.
REQ-034 instr=0xA000: illegal_op=1 in EXEC, no RegWrite, next state FETCH; then instr=0xF000: halted=1 held for 20 cycles; rst returns to IDLE.
REQ-035 Assert rst during a LOAD MEM wait: next cycle state=IDLE, all outputs 0, retired=0.
